// File: rtl/cpu_sequencer.sv
// Instruction sequencer driving the 4-bit accumulator datapath.
// Optional zero flag: define CPU_SEQ_ZERO_FLAG_EN.
module cpu_sequencer #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CPU_SEQ_ZERO_FLAG_EN
  input  logic [DATA_W-1:0] alu_out,
  output logic              zero_flag,
`endif
  input  logic [DATA_W+3:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              carry_out,
  output logic [DATA_W-1:0] mux_in_data,
  output logic [DATA_W-1:0] alu_in_data,
  output logic              mux_sel_data,
  output logic [1:0]        alu_sel_data,
  output logic              load,
  output logic              carry_flag,
  output logic              illegal,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W+3:0] ir;
  logic [3:0]        op;
  logic [DATA_W-1:0] imm;

  logic [DATA_W-1:0] mux_in_q;
  logic [DATA_W-1:0] alu_in_q;
  logic              mux_sel_q;
  logic [1:0]        alu_sel_q;

  logic load_dec;
  logic is_add;
  logic is_clrc;
  logic is_ill;

  assign op  = ir[DATA_W+3:DATA_W];
  assign imm = ir[DATA_W-1:0];

  assign halted = (state == HALT);
  // reset is synchronous but must still squash the strobe in its cycle
  assign load   = load_dec & ~reset;

  always_comb begin
    state_nxt    = state;
    instr_ready  = 1'b0;
    load_dec     = 1'b0;
    is_add       = 1'b0;
    is_clrc      = 1'b0;
    is_ill       = 1'b0;
    mux_in_data  = mux_in_q;
    alu_in_data  = alu_in_q;
    mux_sel_data = mux_sel_q;
    alu_sel_data = alu_sel_q;
    unique case (state)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        unique case (1'b1)
          (op == 4'd1): begin
            load_dec     = 1'b1;
            mux_sel_data = 1'b0;
            mux_in_data  = imm;
          end
          (op >= 4'd2 && op <= 4'd5): begin
            load_dec     = 1'b1;
            is_add       = (op == 4'd2);
            mux_sel_data = 1'b1;
            alu_sel_data = 2'(op - 4'd2);
            alu_in_data  = imm;
          end
          (op == 4'd6): is_clrc = 1'b1;
          (op == 4'd7): state_nxt = HALT;
          op[3]:        is_ill = 1'b1;
          default: ;
        endcase
      end
      HALT: ;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      ir          <= '0;
      mux_in_q    <= '0;
      alu_in_q    <= '0;
      mux_sel_q   <= 1'b0;
      alu_sel_q   <= 2'b00;
      carry_flag  <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && instr_valid) ir <= instr;
      if (state == EXEC) begin
        mux_in_q    <= mux_in_data;
        alu_in_q    <= alu_in_data;
        mux_sel_q   <= mux_sel_data;
        alu_sel_q   <= alu_sel_data;
        instr_count <= instr_count + 1'b1;
        if (is_add)  carry_flag <= carry_out;
        if (is_clrc) carry_flag <= 1'b0;
        if (is_ill)  illegal    <= 1'b1;
      end
    end
  end

`ifdef CPU_SEQ_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_flag <= 1'b0;
    end else if (state == EXEC && load_dec) begin
      if (op == 4'd1) zero_flag <= (imm == '0);
      else            zero_flag <= (alu_out == '0);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer with a
// behavioural datapath and an instruction-level reference model.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       carry_out;
  logic [3:0] mux_in_data, alu_in_data;
  logic       mux_sel_data;
  logic [1:0] alu_sel_data;
  logic       load, carry_flag, illegal, halted;
  logic [7:0] instr_count;
  logic       zero_flag;

  logic [3:0] acc = 4'h0;
  logic [3:0] alu_res;
  logic [4:0] sum;

  int total = 0;
  int bad = 0;

  logic [3:0] ref_acc = 4'h0;
  logic       ref_c, ref_ill, ref_halt, ref_z;
  logic [7:0] ref_cnt;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk),
    .reset(reset),
`ifdef CPU_SEQ_ZERO_FLAG_EN
    .alu_out(alu_res),
    .zero_flag(zero_flag),
`endif
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .carry_out(carry_out),
    .mux_in_data(mux_in_data),
    .alu_in_data(alu_in_data),
    .mux_sel_data(mux_sel_data),
    .alu_sel_data(alu_sel_data),
    .load(load),
    .carry_flag(carry_flag),
    .illegal(illegal),
    .halted(halted),
    .instr_count(instr_count)
  );

`ifndef CPU_SEQ_ZERO_FLAG_EN
  assign zero_flag = 1'b0;
`endif

  // behavioural 4-bit datapath: mux, accumulator, ALU
  always_comb begin
    sum = {1'b0, acc} + {1'b0, alu_in_data};
    case (alu_sel_data)
      2'b00:   alu_res = sum[3:0];
      2'b01:   alu_res = acc | alu_in_data;
      2'b10:   alu_res = acc & alu_in_data;
      default: alu_res = acc ^ alu_in_data;
    endcase
    carry_out = (alu_sel_data == 2'b00) ? sum[4] : 1'b0;
  end

  always @(posedge clk)
    if (load) acc <= mux_sel_data ? alu_res : mux_in_data;

  task automatic model(input logic [3:0] op, input logic [3:0] imm);
    int s;
    s = 0;
    if (op == 1) begin
      ref_acc = imm; ref_z = (imm == 0);
    end else if (op == 2) begin
      s = ref_acc + imm;
      ref_acc = 4'(s % 16); ref_c = (s >= 16); ref_z = (ref_acc == 0);
    end else if (op == 3) begin
      ref_acc = ref_acc | imm; ref_z = (ref_acc == 0);
    end else if (op == 4) begin
      ref_acc = ref_acc & imm; ref_z = (ref_acc == 0);
    end else if (op == 5) begin
      ref_acc = ref_acc ^ imm; ref_z = (ref_acc == 0);
    end else if (op == 6) begin
      ref_c = 1'b0;
    end else if (op == 7) begin
      ref_halt = 1'b1;
    end else if (op >= 8) begin
      ref_ill = 1'b1;
    end
    ref_cnt = 8'((int'(ref_cnt) + 1) % 256);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_c = 0; ref_ill = 0; ref_halt = 0; ref_z = 0; ref_cnt = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] imm,
                       input bit hold);
    int n;
    logic exp_ld;
    n = 0;
    exp_ld = (op >= 1 && op <= 5);
    instr = {op, imm};
    instr_valid = 1'b1;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (!instr_ready) begin
      bad++;
      $display("FAIL accept_timeout op=%0d ready=%b required=1", op, instr_ready);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (!hold) instr_valid = 1'b0;
      total++;
      if (instr_ready !== 1'b0) begin
        bad++; $display("FAIL exec_ready op=%0d got=%b exp=0", op, instr_ready);
      end
      total++;
      if (load !== exp_ld) begin
        bad++; $display("FAIL exec_load op=%0d got=%b exp=%b", op, load, exp_ld);
      end
      if (op == 1) begin
        total++;
        if (mux_sel_data !== 1'b0 || mux_in_data !== imm) begin
          bad++;
          $display("FAIL ldi_decode sel=%b data=%h exp sel=0 data=%h",
                   mux_sel_data, mux_in_data, imm);
        end
      end
      if (op >= 2 && op <= 5) begin
        total++;
        if (mux_sel_data !== 1'b1 || alu_sel_data !== 2'(op - 2) ||
            alu_in_data !== imm) begin
          bad++;
          $display("FAIL alu_decode op=%0d sel=%b alu=%b b=%h exp 1 %b %h",
                   op, mux_sel_data, alu_sel_data, alu_in_data, 2'(op - 2), imm);
        end
      end
      @(posedge clk); #1;
      model(op, imm);
      total++;
      if (acc !== ref_acc) begin
        bad++; $display("FAIL reg op=%0d got=%h exp=%h", op, acc, ref_acc);
      end
      total++;
      if (carry_flag !== ref_c || illegal !== ref_ill) begin
        bad++;
        $display("FAIL flags op=%0d c=%b ill=%b exp c=%b ill=%b",
                 op, carry_flag, illegal, ref_c, ref_ill);
      end
      total++;
      if (instr_count !== ref_cnt) begin
        bad++; $display("FAIL count got=%0d exp=%0d", instr_count, ref_cnt);
      end
      total++;
      if (halted !== ref_halt || instr_ready !== !ref_halt || load !== 1'b0) begin
        bad++;
        $display("FAIL post_exec halted=%b ready=%b load=%b exp %b %b 0",
                 halted, instr_ready, load, ref_halt, !ref_halt);
      end
`ifdef CPU_SEQ_ZERO_FLAG_EN
      total++;
      if (zero_flag !== ref_z) begin
        bad++; $display("FAIL zero_flag got=%b exp=%b", zero_flag, ref_z);
      end
`endif
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (instr_ready !== 1 || load !== 0 || mux_sel_data !== 0 ||
        alu_sel_data !== 0 || mux_in_data !== 0 || alu_in_data !== 0 ||
        carry_flag !== 0 || illegal !== 0 || halted !== 0 ||
        instr_count !== 0 || zero_flag !== 0) begin
      bad++;
      $display("FAIL reset_values rdy=%b ld=%b ms=%b as=%b mi=%h ai=%h c=%b i=%b h=%b n=%0d z=%b",
               instr_ready, load, mux_sel_data, alu_sel_data, mux_in_data,
               alu_in_data, carry_flag, illegal, halted, instr_count, zero_flag);
    end
  endtask

  task automatic test_ldi();
    issue(4'd1, 4'd5, 0);
  endtask

  task automatic test_add_clrc();
    issue(4'd1, 4'd9, 0);
    issue(4'd2, 4'd8, 0);
    total++;
    if (acc !== 4'h1 || carry_flag !== 1'b1) begin
      bad++; $display("FAIL add_carry reg=%h c=%b exp 1 1", acc, carry_flag);
    end
    issue(4'd6, 4'd0, 0);
  endtask

  task automatic test_logic();
    issue(4'd1, 4'hC, 0);
    issue(4'd3, 4'h3, 0);
    issue(4'd4, 4'h5, 0);
    issue(4'd5, 4'hF, 0);
    total++;
    if (acc !== 4'hA) begin
      bad++; $display("FAIL logic_chain got=%h exp=a", acc);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    issue(4'd9, 4'd0, 0);
    issue(4'd1, 4'd2, 0);
    total++;
    if (illegal !== 1 || acc !== 4'h2 || instr_count !== 8'd2) begin
      bad++;
      $display("FAIL illegal_seq ill=%b reg=%h n=%0d exp 1 2 2",
               illegal, acc, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      issue(4'($urandom_range(1, 6)), 4'($urandom), 1);
    instr_valid = 1'b0;
  endtask

  task automatic test_halt();
    logic [3:0] held;
    issue(4'd7, 4'd0, 0);
    held = acc;
    instr = 8'h13;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (halted !== 1 || instr_ready !== 0 || load !== 0 || acc !== held) begin
        bad++;
        $display("FAIL halt_hold h=%b rdy=%b ld=%b reg=%h exp 1 0 0 %h",
                 halted, instr_ready, load, acc, held);
      end
    end
    test_reset();
    issue(4'd1, 4'd3, 0);
  endtask

  task automatic test_reset_exec();
    logic [3:0] held;
    do_reset();
    issue(4'd1, 4'd9, 0);
    held = acc;
    do_reset();
    instr = 8'h28;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (load !== 1'b0) begin
      bad++; $display("FAIL reset_exec_load got=%b exp=0", load);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (acc !== held || carry_flag !== 0 || instr_count !== 0 ||
        instr_ready !== 1) begin
      bad++;
      $display("FAIL reset_exec reg=%h c=%b n=%0d rdy=%b exp %h 0 0 1",
               acc, carry_flag, instr_count, instr_ready, held);
    end
  endtask

  task automatic test_zero();
`ifdef CPU_SEQ_ZERO_FLAG_EN
    issue(4'd1, 4'd3, 0);
    issue(4'd5, 4'd3, 0);
    total++;
    if (zero_flag !== 1'b1) begin
      bad++; $display("FAIL zero_xor got=%b exp=1", zero_flag);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 7) op = op + 1;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(op, 4'($urandom), 0);
    end
  endtask

  initial begin
    ref_c = 0; ref_ill = 0; ref_halt = 0; ref_z = 0; ref_cnt = 0;
    test_reset();
    test_ldi();
    test_add_clrc();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_halt();
    test_reset_exec();
    test_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
